uart_tx_arb: RTL
================

UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 SHALL have parameter N_REQ, default 4, giving the number of requesters (2..8).
REQ-002 SHALL have parameter BUSY_TMO, default 7, giving the maximum number of cycles to wait for the transmitter busy flag to rise.
REQ-003 i_clk  input  1  system clock; all logic is on the rising edge.
REQ-004 i_reset  input  1  reset: synchronous, active-high.
REQ-005 i_req_valid  input  N_REQ  per-requester byte valid.
REQ-006 i_req_dat  input  8*N_REQ  per-requester byte; requester i uses bits [8i+7:8i].
REQ-007 i_req_last  input  N_REQ  per-requester end-of-message flag (used only with the lock feature).
REQ-008 o_req_ready  output  N_REQ  one-cycle accept strobe to the granted requester.
REQ-009 o_tx_cyc  output  1  bus cycle to the uart_tx slave.
REQ-010 o_tx_we  output  1  write enable to the uart_tx slave.
REQ-011 o_tx_dat  output  8  byte to the uart_tx slave.
REQ-012 i_tx_stat  input  8  uart_tx status; bit 0 = transmitter active.
REQ-013 o_grant  output  N_REQ  one-hot current owner; all zero in IDLE.
REQ-014 o_done  output  1  one-cycle pulse when a byte has left the line.
REQ-015 o_err  output  1  one-cycle pulse on busy timeout.

Function
REQ-016 SHALL implement the FSM states IDLE, ISSUE, WAIT_BUSY, WAIT_IDLE.
REQ-017 IDLE: if any i_req_valid is set and i_tx_stat[0]=0, SHALL register the round-robin winner into o_grant and go to ISSUE on the next cycle; otherwise SHALL stay in IDLE.
REQ-018 Round-robin: the search SHALL start at (last granted index + 1) mod N_REQ and the lowest index from that start wins; the last granted index SHALL update on each grant.
REQ-019 ISSUE lasts exactly 1 cycle: o_tx_cyc=o_tx_we=1, o_tx_dat=the winner's byte, o_req_ready[winner]=1; next state is WAIT_BUSY.
REQ-020 Outside ISSUE, o_tx_cyc, o_tx_we and o_req_ready SHALL be 0 and o_tx_dat SHALL be 8'h00.
REQ-021 WAIT_BUSY: on i_tx_stat[0]=1, SHALL go to WAIT_IDLE; after BUSY_TMO cycles with no busy flag, SHALL pulse o_err and go to IDLE.
REQ-022 WAIT_IDLE: on i_tx_stat[0]=0, SHALL pulse o_done for 1 cycle and go to IDLE with o_grant cleared.
REQ-023 A requester SHALL hold valid and data stable until it sees ready; a valid deasserted before ready SHALL NOT cause a bus write.
REQ-024 Minimum spacing between consecutive ISSUE cycles SHALL be 4 cycles plus the transmitter busy time.

Reset
REQ-025 On i_reset, SHALL enter IDLE and set all outputs to 0, last granted index to N_REQ-1 (so requester 0 wins first) and the lock to clear.
REQ-026 Reset during WAIT_BUSY or WAIT_IDLE SHALL abandon the byte with no o_done pulse; the transmitter is not aborted.

Configuration
REQ-027 With UART_TX_ARB_LOCK_EN defined: a byte accepted with i_req_last=0 SHALL lock arbitration to that requester; IDLE SHALL then consider only that requester, and the lock SHALL clear when a byte with last=1 is accepted or on o_err.
REQ-028 Without UART_TX_ARB_LOCK_EN: i_req_last SHALL be ignored and every byte SHALL be re-arbitrated.

Structure
REQ-029 Package uart_tx_arb_pkg SHALL hold the state encoding, the status bit index (0) and the BUSY_TMO default.
REQ-030 The round-robin search SHALL be a combinational sub-module rr_pick (inputs: request vector and start index; outputs: one-hot grant and index).

Verification
REQ-031 Reset, then requester 0 sends 8'h41 while the bench instantiates uart_tx (25 MHz, 115200 baud) -> ISSUE occurs 1 cycle after valid, tx carries 0x41 framed 8N1, o_done pulses once.
REQ-032 All 4 requesters are held valid continuously -> grant order is 0,1,2,3,0 with one byte each.
REQ-033 A stub holds stat[0]=0 after a write -> o_err pulses exactly 7 cycles after WAIT_BUSY entry and the FSM returns to IDLE.
REQ-034 With LOCK_EN, requester 2 sends 3 bytes with last=0,0,1 while requester 0 is also valid -> 2,2,2 then 0.
REQ-035 i_reset asserted mid-WAIT_IDLE -> next cycle all outputs are 0, no o_done pulse, and requester 0 is granted next.
REQ-036 stat[0]=1 while valid is set in IDLE -> no ISSUE occurs until stat[0] falls.

Source files
------------

// File: rtl/uart_tx_arb_pkg.sv
// Shared definitions for the uart_tx arbiter: FSM encoding, status bit
// position and default busy timeout.
package uart_tx_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_IDLE = 2'd3
    } arb_state_t;

    localparam int STAT_BUSY_BIT = 0;
    localparam int BUSY_TMO_DEF  = 7;

    // Index width that never collapses to zero bits.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational round-robin search: the first set request found when
// walking upward from 'start' (wrapping) wins.
module rr_pick
    import uart_tx_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IW    = idx_width(N_REQ)
)(
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    start,
    output logic             any,
    output logic [N_REQ-1:0] grant,
    output logic [IW-1:0]    idx
);

    int            p;
    logic [IW-1:0] pi;

    // Walk the requests from the start index and keep the first hit.
    always_comb begin
        any   = 1'b0;
        grant = '0;
        idx   = '0;
        p     = 0;
        pi    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            p  = (int'(start) + k) % N_REQ;
            pi = IW'(p);
            if (!any && req[pi]) begin
                any       = 1'b1;
                grant[pi] = 1'b1;
                idx       = pi;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter feeding single bytes from N_REQ requesters into a
// uart_tx slave, waiting for each byte to leave the line before the next.
// Optional feature: define UART_TX_ARB_LOCK_EN to keep arbitration locked
// on one requester until it sends a byte flagged last.
//
// state        | meaning
// -------------+-----------------------------------------------------
// ST_IDLE      | no owner; grant winner when a request is valid and tx idle
// ST_ISSUE     | one-cycle bus write of the owner's byte, ready strobe
// ST_WAIT_BUSY | wait up to BUSY_TMO cycles for the tx active flag to rise
// ST_WAIT_IDLE | byte on the line; wait for tx active flag to fall
module uart_tx_arb
    import uart_tx_arb_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int BUSY_TMO = BUSY_TMO_DEF
)(
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [N_REQ-1:0]     i_req_valid,
    input  logic [8*N_REQ-1:0]   i_req_dat,
    input  logic [N_REQ-1:0]     i_req_last,
    output logic [N_REQ-1:0]     o_req_ready,
    output logic                 o_tx_cyc,
    output logic                 o_tx_we,
    output logic [7:0]           o_tx_dat,
    input  logic [7:0]           i_tx_stat,
    output logic [N_REQ-1:0]     o_grant,
    output logic                 o_done,
    output logic                 o_err
);

    localparam int IW = idx_width(N_REQ);
    localparam int TW = idx_width(BUSY_TMO + 1);
    localparam logic [TW-1:0] TMO_LOAD = TW'(BUSY_TMO - 1);
    localparam logic [IW-1:0] IDX_MAX  = IW'(N_REQ - 1);

    arb_state_t        state, state_nxt;
    logic [IW-1:0]     grant_idx_q;
    logic [IW-1:0]     last_idx_q;
    logic [TW-1:0]     tmo_cnt;
    logic [IW-1:0]     start_idx;
    logic [N_REQ-1:0]  req_eff;
    logic              pick_any;
    logic [N_REQ-1:0]  pick_grant;
    logic [IW-1:0]     pick_idx;
    logic              tx_busy;
    logic              issue_ok;
    logic              accept;
    logic              tmo_hit;
    logic              unused_inputs;

    assign tx_busy  = i_tx_stat[STAT_BUSY_BIT];
    // A requester that dropped valid before its ready never gets written.
    assign issue_ok = i_req_valid[grant_idx_q];
    assign accept   = (state == ST_ISSUE) && issue_ok;
    assign tmo_hit  = (state == ST_WAIT_BUSY) && !tx_busy && (tmo_cnt == '0);
    assign start_idx = (last_idx_q == IDX_MAX) ? '0 : last_idx_q + IW'(1);
    assign unused_inputs = &{1'b0, i_req_last, i_tx_stat[7:1]};

`ifdef UART_TX_ARB_LOCK_EN
    logic              lock_q;
    logic [IW-1:0]     lock_idx_q;

    assign req_eff = lock_q ? (i_req_valid & (N_REQ'(1) << lock_idx_q)) : i_req_valid;

    // Lock follows the last flag of each accepted byte; a timeout releases it.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else if (accept) begin
            lock_q     <= !i_req_last[grant_idx_q];
            lock_idx_q <= grant_idx_q;
        end else if (tmo_hit) begin
            lock_q     <= 1'b0;
        end
    end
`else
    assign req_eff = i_req_valid;
`endif

    rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
        .req   (req_eff),
        .start (start_idx),
        .any   (pick_any),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:      if (pick_any && !tx_busy) state_nxt = ST_ISSUE;
            ST_ISSUE:     state_nxt = issue_ok ? ST_WAIT_BUSY : ST_IDLE;
            ST_WAIT_BUSY: begin
                if (tx_busy)      state_nxt = ST_WAIT_IDLE;
                else if (tmo_hit) state_nxt = ST_IDLE;
            end
            ST_WAIT_IDLE: if (!tx_busy) state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    // Bus write and ready strobe, only during an accepted ISSUE cycle.
    always_comb begin
        o_tx_cyc    = accept;
        o_tx_we     = accept;
        o_tx_dat    = accept ? i_req_dat[{grant_idx_q, 3'b000} +: 8] : 8'h00;
        o_req_ready = accept ? o_grant : '0;
    end

    // Owner, round-robin pointer, busy timer and done/err pulses.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_grant     <= '0;
            grant_idx_q <= '0;
            last_idx_q  <= IDX_MAX;
            tmo_cnt     <= '0;
            o_done      <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            o_done <= (state == ST_WAIT_IDLE) && !tx_busy;
            o_err  <= tmo_hit;
            if (state == ST_IDLE && state_nxt == ST_ISSUE) begin
                o_grant     <= pick_grant;
                grant_idx_q <= pick_idx;
                last_idx_q  <= pick_idx;
            end else if (state != ST_IDLE && state_nxt == ST_IDLE) begin
                o_grant     <= '0;
            end
            if (state == ST_ISSUE)
                tmo_cnt <= TMO_LOAD;
            else if (state == ST_WAIT_BUSY && tmo_cnt != '0)
                tmo_cnt <= tmo_cnt - TW'(1);
        end
    end

endmodule
